// File: rtl/gf_pb_pkg.sv
// rtl/gf_pb_pkg.sv - GF(2^13) polynomial-basis field constants, types and multiply helper
package gf_pb_pkg;

    localparam int M = 13;
    localparam logic [M-1:0] POLY = 13'h001B;
    localparam logic [3:0] LOOP_LAST = 4'(M - 3);

    typedef logic [M-1:0] gf_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOOP,
        FINAL,
        DONE
    } div_state_e;

    // Shift-add multiply; x^M folds back into the low terms of p(x) as the operand shifts.
    function automatic gf_t gf_mul(input gf_t x, input gf_t y);
        gf_t acc;
        gf_t t;
        acc = '0;
        t = x;
        for (int i = 0; i < M; i++) begin
            if (y[i]) begin
                acc = acc ^ t;
            end
            t = t[M-1] ? ((t << 1) ^ POLY) : (t << 1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/gf_pb_sqr.sv
// rtl/gf_pb_sqr.sv - combinational GF(2^13) PB squarer: bit spread then fixed reduction
module gf_pb_sqr
    import gf_pb_pkg::*;
(
    input  logic [M-1:0] a,
    output logic [M-1:0] y
);

    localparam int W = 2 * M - 1;
    localparam logic [W-1:0] RED = {{(W - M - 1){1'b0}}, 1'b1, POLY};

    logic [W-1:0] w;

    // Top-down fold: each XOR clears bit k and may set bits below it, handled by later steps.
    always_comb begin
        w = '0;
        for (int i = 0; i < M; i++) begin
            w[2*i] = a[i];
        end
        for (int k = W - 1; k >= M; k--) begin
            if (w[k]) begin
                w = w ^ (RED << (k - M));
            end
        end
        y = w[M-1:0];
    end

endmodule

// File: rtl/gf_pb_div.sv
// rtl/gf_pb_div.sv - sequential GF(2^13) divider q=a/b via Fermat inverse; option GF_DIV_ZERO_FAST_EN
module gf_pb_div
    import gf_pb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] q,
    output logic         div_zero
);

    div_state_e state;
    gf_t        a_r;
    gf_t        b_r;
    gf_t        s;
    gf_t        r;
    logic [3:0] cnt;

    gf_t sqr_in;
    gf_t sq;
    gf_t mul_x;
    gf_t mul_y;
    gf_t prod;

    // The single squarer and multiplier are shared; FINAL reuses the multiplier for a_r*r.
    always_comb begin
        sqr_in = (state == INIT) ? b_r : s;
        mul_x  = (state == FINAL) ? a_r : r;
        mul_y  = (state == FINAL) ? r : sq;
        prod   = gf_mul(mul_x, mul_y);
    end

    gf_pb_sqr u_sqr (
        .a(sqr_in),
        .y(sq)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_r       <= '0;
            b_r       <= '0;
            s         <= '0;
            r         <= '0;
            cnt       <= '0;
            q         <= '0;
            div_zero  <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= b;
                        in_ready <= 1'b0;
`ifdef GF_DIV_ZERO_FAST_EN
                        if (b == '0) begin
                            q         <= '0;
                            div_zero  <= 1'b1;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= INIT;
                        end
`else
                        state <= INIT;
`endif
                    end
                end
                INIT: begin
                    s     <= sq;
                    r     <= sq;
                    cnt   <= '0;
                    state <= LOOP;
                end
                LOOP: begin
                    // r accumulates b^(2^1) * ... * b^(2^(cnt+2)); ends at b^(2^M-2).
                    s   <= sq;
                    r   <= prod;
                    cnt <= cnt + 4'd1;
                    if (cnt == LOOP_LAST) begin
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    q         <= prod;
                    div_zero  <= (b_r == '0);
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf_pb_div.sv
// tb/tb_gf_pb_div.sv - self-checking bench for gf_pb_div against a field-arithmetic model
module tb_gf_pb_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] da;
    logic [12:0] db;
    logic        out_valid;
    logic        out_ready;
    logic [12:0] q;
    logic        div_zero;

    int n_chk;
    int n_fail;
    int cyc;

    gf_pb_div dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(da),
        .b(db),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .q(q),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

`ifdef GF_DIV_ZERO_FAST_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 13;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Full carry-less product, then polynomial long division by x^13+x^4+x^3+x+1.
    function automatic logic [12:0] bmul(input logic [12:0] x, input logic [12:0] y);
        logic [24:0] p;
        p = '0;
        for (int i = 0; i < 13; i++) begin
            if (y[i]) p = p ^ (25'(x) << i);
        end
        for (int k = 24; k >= 13; k--) begin
            if (p[k]) p = p ^ (25'(14'h201B) << (k - 13));
        end
        return p[12:0];
    endfunction

    function automatic logic [12:0] bpow(input logic [12:0] x, input int e);
        logic [12:0] res;
        logic [12:0] base;
        int          n;
        res = 13'h0001;
        base = x;
        n = e;
        while (n != 0) begin
            if (n[0]) res = bmul(res, base);
            base = bmul(base, base);
            n = n >> 1;
        end
        return res;
    endfunction

    function automatic logic [12:0] bdiv(input logic [12:0] x, input logic [12:0] y);
        if (y == 13'h0) return 13'h0;
        return bmul(x, bpow(y, 8190));
    endfunction

    typedef struct {
        logic [12:0] a;
        logic [12:0] b;
        logic [12:0] q;
        logic        dz;
        int          acc;
    } exp_t;

    exp_t eq[$];
    bit   head_seen;

    always @(negedge clk) begin
        if (rst) begin
            eq.delete();
            head_seen = 1'b0;
        end else begin
            if (eq.size() == 0) begin
                chk("idle_out_valid", 32'(out_valid), 32'd0);
                chk("idle_in_ready", 32'(in_ready), 32'd1);
            end else begin
                chk("busy_in_ready", 32'(in_ready), 32'd0);
                if (out_valid) begin
                    if (!head_seen) begin
                        chk("latency", 32'(cyc - eq[0].acc - 1),
                            32'((eq[0].b == 13'h0) ? ZERO_LAT : 13));
                        head_seen = 1'b1;
                    end
                    chk("q", 32'(q), 32'(eq[0].q));
                    chk("div_zero", 32'(div_zero), 32'(eq[0].dz));
                    if (eq[0].b != 13'h0) chk("q_times_b", 32'(bmul(q, eq[0].b)), 32'(eq[0].a));
                    if (out_ready) begin
                        void'(eq.pop_front());
                        head_seen = 1'b0;
                    end
                end else if (cyc - eq[0].acc - 1 == 20) begin
                    chk("out_valid_late", 32'd0, 32'd1);
                end
            end
            if (in_valid && in_ready) begin
                eq.push_back('{a: da, b: db, q: bdiv(da, db), dz: (db == 13'h0), acc: cyc});
            end
        end
    end

    logic [12:0] got_q;
    logic        got_dz;

    task automatic accept_op(input logic [12:0] a, input logic [12:0] b);
        int t;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        da = a;
        db = b;
        t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        da = 13'($urandom);
        db = 13'($urandom);
    endtask

    task automatic wait_result(input int stall, input bit compete);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("result_timeout", 32'(out_valid), 32'd1);
        got_q = q;
        got_dz = div_zero;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            if (compete) begin
                in_valid = 1'b1;
                da = 13'h0005;
                db = 13'h0007;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [12:0] a, input logic [12:0] b, input int stall, input bit compete);
        out_ready = (stall < 0);
        accept_op(a, b);
        wait_result((stall < 0) ? 0 : stall, compete);
    endtask

    initial begin
        logic [12:0] ra;
        logic [12:0] rb;
        n_chk = 0;
        n_fail = 0;
        cyc = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        da = '0;
        db = '0;

        chk("model_x_inv", 32'(bdiv(13'h0001, 13'h0002)), 32'h100D);
        chk("model_x_times_xinv", 32'(bmul(13'h100D, 13'h0002)), 32'h0001);
        chk("model_x24", 32'(bmul(13'h1000, 13'h1000)), 32'h185A);
        chk("model_self_div", 32'(bdiv(13'h1ABC, 13'h1ABC)), 32'h0001);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_q", 32'(q), 32'd0);
        chk("rst_div_zero", 32'(div_zero), 32'd0);

        run_op(13'h0001, 13'h0001, -1, 1'b0);
        chk("t1_q", 32'(got_q), 32'h0001);
        chk("t1_dz", 32'(got_dz), 32'd0);

        run_op(13'h0001, 13'h0002, 0, 1'b0);
        chk("t2_q", 32'(got_q), 32'h100D);
        chk("t2_dz", 32'(got_dz), 32'd0);

        run_op(13'h1ABC, 13'h0000, 1, 1'b0);
        chk("t3_q", 32'(got_q), 32'h0000);
        chk("t3_dz", 32'(got_dz), 32'd1);

        run_op(13'h0000, 13'h0123, 0, 1'b0);
        chk("a0_q", 32'(got_q), 32'h0000);
        chk("a0_dz", 32'(got_dz), 32'd0);

        out_ready = 1'b0;
        accept_op(13'h0003, 13'h0002);
        wait_result(5, 1'b1);
        chk("t4_q", 32'(got_q), 32'(bdiv(13'h0003, 13'h0002)));
        @(negedge clk);
        chk("t4_idle_ready", 32'(in_ready), 32'd1);
        run_op(13'h0002, 13'h0001, 0, 1'b0);
        chk("t4_next_q", 32'(got_q), 32'h0002);

        accept_op(13'h1234, 13'h0777);
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 32'(out_valid), 32'd0);
        chk("t5_in_ready", 32'(in_ready), 32'd1);
        run_op(13'h0002, 13'h0002, 0, 1'b0);
        chk("t5_q", 32'(got_q), 32'h0001);

        for (int n = 0; n < 2000; n++) begin
            ra = 13'($urandom_range(1, 8191));
            rb = 13'($urandom_range(1, 8191));
            if ($urandom_range(0, 7) == 0) ra = rb;
            run_op(ra, rb, int'($urandom_range(0, 4)) - 1, 1'b0);
            chk("rand_q_times_b", 32'(bmul(got_q, rb)), 32'(ra));
            if (ra == rb) chk("rand_self_div", 32'(got_q), 32'h0001);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
